// File: rtl/tcm_data_arbiter.sv
// Two-master OBI-style arbiter in front of a single-port data TCM: combinational grant,
// one-cycle read latency, round-robin with core-priority override, saturating conflict counter.
module tcm_data_arbiter #(
  parameter int MEM_AW = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              m0_req_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  input  logic              m0_we_i,
  input  logic [3:0]        m0_be_i,
  input  logic [31:0]       m0_addr_i,
  input  logic [31:0]       m0_wdata_i,
  output logic [31:0]       m0_rdata_o,

  input  logic              m1_req_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  input  logic              m1_we_i,
  input  logic [3:0]        m1_be_i,
  input  logic [31:0]       m1_addr_i,
  input  logic [31:0]       m1_wdata_i,
  output logic [31:0]       m1_rdata_o,

  input  logic              prio_core_i,

  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,

  input  logic              cnt_clr_i,
  output logic [CNT_W-1:0]  conflict_cnt_o
);

  logic             last_grant;
  logic             rvalid0_q;
  logic             rvalid1_q;
  logic [CNT_W-1:0] cnt_q;
  logic             conflict;

  assign conflict = m0_req_i & m1_req_i;

  // last_grant holds the index of the most recently granted master; the other one wins a tie.
  assign m0_gnt_o = m0_req_i & (~m1_req_i | prio_core_i | last_grant);
  assign m1_gnt_o = m1_req_i & ~m0_gnt_o;

  always_comb begin
    mem_req_o   = m0_gnt_o | m1_gnt_o;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (m0_gnt_o) begin
      mem_we_o    = m0_we_i;
      mem_be_o    = m0_be_i;
      mem_addr_o  = m0_addr_i[MEM_AW+1:2];
      mem_wdata_o = m0_wdata_i;
    end else if (m1_gnt_o) begin
      mem_we_o    = m1_we_i;
      mem_be_o    = m1_be_i;
      mem_addr_o  = m1_addr_i[MEM_AW+1:2];
      mem_wdata_o = m1_wdata_i;
    end
  end

  // Address decode is done upstream, so the byte offset and upper bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr_i[31:MEM_AW+2], m0_addr_i[1:0],
                              m1_addr_i[31:MEM_AW+2], m1_addr_i[1:0]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant <= 1'b1;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      rvalid0_q <= m0_gnt_o;
      rvalid1_q <= m1_gnt_o;
      if (m0_gnt_o) begin
        last_grant <= 1'b0;
      end else if (m1_gnt_o) begin
        last_grant <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (cnt_clr_i) begin
      cnt_q <= '0;
    end else if (conflict && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign m0_rvalid_o    = rvalid0_q;
  assign m1_rvalid_o    = rvalid1_q;
  assign m0_rdata_o     = rvalid0_q ? mem_rdata_i : '0;
  assign m1_rdata_o     = rvalid1_q ? mem_rdata_i : '0;
  assign conflict_cnt_o = cnt_q;

  a_one_gnt : assert property (@(posedge clk_i) disable iff (rst_i) !(m0_gnt_o && m1_gnt_o));
  a_one_rvalid : assert property (@(posedge clk_i) disable iff (rst_i) !(m0_rvalid_o && m1_rvalid_o));

endmodule

// File: tb/tb_tcm_data_arbiter.sv
// Scoreboard bench for tcm_data_arbiter: a reference arbiter/memory model predicts grants,
// SRAM drive and responses, which are queued and compared a cycle later.
module tb_tcm_data_arbiter;

  localparam int MEM_AW = 12;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 1 << MEM_AW;

  logic              clk_i;
  logic              rst_i;
  logic              m0_req_i, m0_gnt_o, m0_rvalid_o, m0_we_i;
  logic [3:0]        m0_be_i;
  logic [31:0]       m0_addr_i, m0_wdata_i, m0_rdata_o;
  logic              m1_req_i, m1_gnt_o, m1_rvalid_o, m1_we_i;
  logic [3:0]        m1_be_i;
  logic [31:0]       m1_addr_i, m1_wdata_i, m1_rdata_o;
  logic              prio_core_i;
  logic              mem_req_o, mem_we_o;
  logic [3:0]        mem_be_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;
  logic              cnt_clr_i;
  logic [CNT_W-1:0]  conflict_cnt_o;

  tcm_data_arbiter #(.MEM_AW(MEM_AW), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_we_i(m0_we_i),
    .m0_be_i(m0_be_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_we_i(m1_we_i),
    .m1_be_i(m1_be_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_rdata_o(m1_rdata_o),
    .prio_core_i(prio_core_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .cnt_clr_i(cnt_clr_i), .conflict_cnt_o(conflict_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Behavioural SRAM driven only by the DUT's mem_* outputs.
  logic [31:0] sram [0:DEPTH-1];
  always @(posedge clk_i) begin
    if (mem_req_o) begin
      mem_rdata_i <= sram[mem_addr_o];
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
      end
    end
  end

  typedef struct {
    logic        master;
    logic        is_write;
    logic [31:0] data;
  } resp_t;

  resp_t       sb_q[$];
  logic [31:0] ref_mem [0:DEPTH-1];
  logic        m_last;
  int          m_cnt;
  int          n_checks;
  int          n_errors;

  function automatic logic [31:0] init_word(input int i);
    return (i * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Drives one cycle of stimulus, checks the current response and grant, then advances the model.
  task automatic apply_stimulus(
    input logic r0, input logic w0, input logic [3:0] be0, input logic [31:0] a0, input logic [31:0] d0,
    input logic r1, input logic w1, input logic [3:0] be1, input logic [31:0] a1, input logic [31:0] d1,
    input logic prio, input logic clr);
    resp_t       e;
    logic        g0, g1, ew;
    logic [3:0]  ebe;
    logic [31:0] ea, ed;
    int          word;
    @(negedge clk_i);
    m0_req_i = r0; m0_we_i = w0; m0_be_i = be0; m0_addr_i = a0; m0_wdata_i = d0;
    m1_req_i = r1; m1_we_i = w1; m1_be_i = be1; m1_addr_i = a1; m1_wdata_i = d1;
    prio_core_i = prio; cnt_clr_i = clr;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_output("m0_rvalid", 32'(m0_rvalid_o), 32'(e.master == 1'b0));
      check_output("m1_rvalid", 32'(m1_rvalid_o), 32'(e.master == 1'b1));
      if (e.master == 1'b0) begin
        if (!e.is_write) check_output("m0_rdata", m0_rdata_o, e.data);
        check_output("m1_rdata_idle", m1_rdata_o, 32'h0);
      end else begin
        if (!e.is_write) check_output("m1_rdata", m1_rdata_o, e.data);
        check_output("m0_rdata_idle", m0_rdata_o, 32'h0);
      end
    end else begin
      check_output("m0_rvalid_idle", 32'(m0_rvalid_o), 32'h0);
      check_output("m1_rvalid_idle", 32'(m1_rvalid_o), 32'h0);
      check_output("m0_rdata_idle", m0_rdata_o, 32'h0);
      check_output("m1_rdata_idle", m1_rdata_o, 32'h0);
    end

    g0 = r0 && (!r1 || prio || m_last);
    g1 = r1 && !g0;
    ew = 1'b0; ebe = 4'h0; ea = 32'h0; ed = 32'h0;
    if (g0) begin
      ew = w0; ebe = be0; ea = 32'(a0[MEM_AW+1:2]); ed = d0;
    end else if (g1) begin
      ew = w1; ebe = be1; ea = 32'(a1[MEM_AW+1:2]); ed = d1;
    end
    check_output("m0_gnt", 32'(m0_gnt_o), 32'(g0));
    check_output("m1_gnt", 32'(m1_gnt_o), 32'(g1));
    check_output("mem_req", 32'(mem_req_o), 32'(g0 | g1));
    check_output("mem_we", 32'(mem_we_o), 32'(ew));
    check_output("mem_be", 32'(mem_be_o), 32'(ebe));
    check_output("mem_addr", 32'(mem_addr_o), ea);
    check_output("mem_wdata", mem_wdata_o, ed);
    check_output("conflict_cnt", 32'(conflict_cnt_o), 32'(m_cnt));

    if (g0 || g1) begin
      word = int'(ea);
      e.master   = g1;
      e.is_write = ew;
      e.data     = ref_mem[word];
      sb_q.push_back(e);
      if (ew) begin
        for (int b = 0; b < 4; b++) begin
          if (ebe[b]) ref_mem[word][8*b +: 8] = ed[8*b +: 8];
        end
      end
      m_last = g1;
    end
    if (clr) m_cnt = 0;
    else if (r0 && r1 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    @(posedge clk_i);
  endtask

  task automatic idle_cycle();
    apply_stimulus(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic both_read(input logic [31:0] a0, input logic [31:0] a1, input logic prio, input logic clr);
    apply_stimulus(1, 0, 4'hF, a0, 32'h0, 1, 0, 4'hF, a1, 32'h0, prio, clr);
  endtask

  initial begin
    logic [31:0] rnd;
    logic [31:0] ra0, ra1;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < DEPTH; i++) begin
      sram[i]    = init_word(i);
      ref_mem[i] = init_word(i);
    end
    sram[4]    = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
    m_last = 1'b1;
    m_cnt  = 0;
    rst_i = 1'b1;
    m0_req_i = 0; m0_we_i = 0; m0_be_i = 0; m0_addr_i = 0; m0_wdata_i = 0;
    m1_req_i = 0; m1_we_i = 0; m1_be_i = 0; m1_addr_i = 0; m1_wdata_i = 0;
    prio_core_i = 0; cnt_clr_i = 0;
    mem_rdata_i = 32'h0;
    repeat (2) @(posedge clk_i);
    #1;
    check_output("rst_m0_rvalid", 32'(m0_rvalid_o), 32'h0);
    check_output("rst_m1_rvalid", 32'(m1_rvalid_o), 32'h0);
    check_output("rst_cnt", 32'(conflict_cnt_o), 32'h0);
    check_output("rst_mem_req", 32'(mem_req_o), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    $display("[TB] single-master read");
    apply_stimulus(1, 0, 4'hF, 32'h0000_0010, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0);
    idle_cycle();
    apply_stimulus(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'hF, 32'hF000_0024, 32'h0, 0, 0);
    idle_cycle();

    $display("[TB] round-robin");
    apply_stimulus(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'hF, 32'h0000_0040, 32'h0, 0, 0);
    both_read(32'h0000_0100, 32'h0000_0204, 0, 0);
    both_read(32'h0000_0108, 32'h0000_020C, 0, 0);
    both_read(32'h0000_0110, 32'h0000_0214, 0, 0);
    both_read(32'h0000_0118, 32'h0000_021C, 0, 0);
    idle_cycle();

    $display("[TB] core priority");
    both_read(32'h0000_0300, 32'h0000_0400, 1, 0);
    both_read(32'h0000_0304, 32'h0000_0404, 1, 0);
    both_read(32'h0000_0308, 32'h0000_0408, 1, 0);
    both_read(32'h0000_030C, 32'h0000_040C, 0, 0);
    idle_cycle();

    $display("[TB] write pipelining");
    apply_stimulus(0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 4'b0011, 32'h0000_0008, 32'h1234_5678, 0, 0);
    apply_stimulus(1, 0, 4'hF, 32'h0000_0008, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0);
    idle_cycle();

    $display("[TB] counter saturation and clear");
    apply_stimulus(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1);
    for (int i = 0; i < 20; i++) both_read(32'(i) << 2, 32'(i + 64) << 2, 0, 0);
    both_read(32'h0000_0010, 32'h0000_0020, 0, 1);
    both_read(32'h0000_0014, 32'h0000_0024, 0, 0);
    idle_cycle();
    idle_cycle();

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++) begin
      rnd = $urandom;
      ra0 = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 7)) << 2);
      ra1 = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 7)) << 2);
      apply_stimulus(rnd[0], rnd[1], rnd[5:2], ra0, $urandom,
                     rnd[6], rnd[7], rnd[11:8], ra1, $urandom,
                     (rnd[13:12] == 2'b00), (rnd[16:14] == 3'b000));
    end
    idle_cycle();

    $display("[TB] reset mid-operation");
    both_read(32'h0000_0050, 32'h0000_0060, 1, 0);
    apply_stimulus(1, 0, 4'hF, 32'h0000_0054, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0);
    #1;
    rst_i = 1'b1;
    m0_req_i = 0; m1_req_i = 0;
    #1;
    check_output("midrst_m0_rvalid", 32'(m0_rvalid_o), 32'h0);
    check_output("midrst_m0_rdata", m0_rdata_o, 32'h0);
    check_output("midrst_cnt", 32'(conflict_cnt_o), 32'h0);
    sb_q.delete();
    m_last = 1'b1;
    m_cnt  = 0;
    @(negedge clk_i);
    rst_i = 1'b0;
    idle_cycle();
    both_read(32'h0000_0070, 32'h0000_0080, 0, 0);
    both_read(32'h0000_0074, 32'h0000_0084, 0, 0);
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
